// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus four-state stability filter for a bouncing button.
// Define DEBOUNCER_INVERT_INPUT_EN to invert signal_input ahead of the synchroniser.
module button_debouncer #(
   parameter int STABLE_CYCLES = 50000,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic clk,
   input  logic sync_reset,
   input  logic signal_input,
   output logic signal_output,
   output logic pending
);

   typedef enum logic [1:0] {
      STABLE_LOW,
      PENDING_HIGH,
      STABLE_HIGH,
      PENDING_LOW
   } state_e;

   localparam logic [COUNTER_WIDTH-1:0] CntLast = COUNTER_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [COUNTER_WIDTH-1:0] CntOne  = COUNTER_WIDTH'(1);

   logic raw;
   logic ff1_q, ff2_q;
   state_e state_q, state_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic out_q, out_d;
   logic pend_q, pend_d;

`ifdef DEBOUNCER_INVERT_INPUT_EN
   assign raw = ~signal_input;
`else
   assign raw = signal_input;
`endif

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         ff1_q   <= 1'b0;
         ff2_q   <= 1'b0;
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         ff1_q   <= raw;
         ff2_q   <= ff1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         pend_q  <= pend_d;
      end
   end

   // Counter is cleared on every state entry, so it never exceeds CntLast.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      pend_d  = pend_q;
      unique case (state_q)
         STABLE_LOW: begin
            if (ff2_q) begin
               state_d = PENDING_HIGH;
               cnt_d   = '0;
               pend_d  = 1'b1;
            end
         end
         PENDING_HIGH: begin
            if (!ff2_q) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (cnt_q == CntLast) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
               out_d   = 1'b1;
               pend_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         STABLE_HIGH: begin
            if (!ff2_q) begin
               state_d = PENDING_LOW;
               cnt_d   = '0;
               pend_d  = 1'b1;
            end
         end
         PENDING_LOW: begin
            if (ff2_q) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (cnt_q == CntLast) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
               out_d   = 1'b0;
               pend_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            out_d   = 1'b0;
            pend_d  = 1'b0;
         end
      endcase
   end

   assign signal_output = out_q;
   assign pending       = pend_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a run-length model.
// Honours DEBOUNCER_INVERT_INPUT_EN the same way the design does.
module tb_button_debouncer;

   localparam int SC = 4;

`ifdef DEBOUNCER_INVERT_INPUT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic clk;
   logic sync_reset;
   logic signal_input;
   logic signal_output;
   logic pending;

   int errs;
   int checks;

   // Model: two-sample delay line and length of the current run of
   // synchronised samples that disagree with the accepted level.
   logic m_q1, m_q2, m_out;
   int   m_run;

   button_debouncer #(
      .STABLE_CYCLES(SC),
      .COUNTER_WIDTH(16)
   ) dut (
      .clk          (clk),
      .sync_reset   (sync_reset),
      .signal_input (signal_input),
      .signal_output(signal_output),
      .pending      (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   // Logical level: 1 means "pressed" in either build.
   task automatic drive(input logic lvl);
      signal_input = lvl ^ INV;
   endtask

   task automatic tick();
      logic r, x, s;
      @(posedge clk);
      r = sync_reset;
      x = signal_input ^ INV;
      #1;
      if (r) begin
         m_q1 = 0; m_q2 = 0; m_out = 0; m_run = 0;
      end else begin
         s = m_q2;
         m_q2 = m_q1;
         m_q1 = x;
         if (s != m_out) begin
            m_run++;
            if (m_run == SC + 1) begin
               m_out = ~m_out;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      check("model_out", signal_output, m_out);
      check("model_pend", pending, m_run != 0);
   endtask

   task automatic hold(input logic lvl, input int n);
      drive(lvl);
      repeat (n) tick();
   endtask

   initial begin
      errs = 0;
      checks = 0;
      m_q1 = 0; m_q2 = 0; m_out = 0; m_run = 0;
      sync_reset = 1'b1;
      drive(1'b1);

      // Reset held with input pressed
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_out", signal_output, 1'b0);
         check("rst_pend", pending, 1'b0);
      end
      sync_reset = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         tick();
         if (k == 5) check("rel_out5", signal_output, 1'b0);
         if (k == 6) check("rel_out6", signal_output, 1'b1);
      end

      // Back to idle, then a clean press and release
      hold(1'b0, 10);
      drive(1'b1);
      for (int k = 0; k <= 6; k++) begin
         tick();
         if (k == 1) check("press_pend1", pending, 1'b0);
         if (k == 2) check("press_pend2", pending, 1'b1);
         if (k == 5) check("press_out5", signal_output, 1'b0);
         if (k == 6) check("press_out6", signal_output, 1'b1);
         if (k == 6) check("press_pend6", pending, 1'b0);
      end
      hold(1'b1, 3);
      drive(1'b0);
      for (int k = 0; k <= 6; k++) begin
         tick();
         if (k == 5) check("rel_hi5", signal_output, 1'b1);
         if (k == 6) check("rel_lo6", signal_output, 1'b0);
      end
      hold(1'b0, 5);

      // Bounce pattern never qualifies
      begin
         logic [5:0] pat;
         logic seen_pend;
         pat = 6'b011011;
         seen_pend = 1'b0;
         for (int i = 5; i >= 0; i--) begin
            drive(pat[i]);
            tick();
            seen_pend |= pending;
            check("bounce_out", signal_output, 1'b0);
         end
         drive(1'b0);
         for (int i = 0; i < 8; i++) begin
            tick();
            seen_pend |= pending;
            check("bounce_hold", signal_output, 1'b0);
         end
         check("bounce_pend_seen", seen_pend, 1'b1);
      end

      // Boundary pulses: 5 cycles accepted, 4 cycles rejected
      begin
         int hi;
         hi = 0;
         hold(1'b1, 5);
         drive(1'b0);
         for (int i = 0; i < 15; i++) begin
            tick();
            if (signal_output) hi++;
         end
         check("pulse5_seen", hi > 0, 1'b1);
         check("pulse5_final", signal_output, 1'b0);
         hi = 0;
         hold(1'b1, 4);
         drive(1'b0);
         for (int i = 0; i < 15; i++) begin
            tick();
            if (signal_output) hi++;
         end
         check("pulse4_none", hi == 0, 1'b1);
      end

      // Reset mid-qualification (cnt==2 after edge S+4)
      drive(1'b1);
      repeat (5) tick();
      check("mid_pend", pending, 1'b1);
      sync_reset = 1'b1;
      tick();
      check("mid_rst_out", signal_output, 1'b0);
      check("mid_rst_pend", pending, 1'b0);
      sync_reset = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         tick();
         if (k == 5) check("mid_out5", signal_output, 1'b0);
         if (k == 6) check("mid_out6", signal_output, 1'b1);
      end

      // Active-low style press: raw idle 1, raw 0 for 10 cycles
      signal_input = 1'b1;
      repeat (12) tick();
      signal_input = 1'b0;
      repeat (10) tick();
      signal_input = 1'b1;
      repeat (12) tick();

      // Terminal-edge toggle and random segments
      hold(1'b0, 10);
      drive(1'b1);
      repeat (6) tick();
      drive(1'b0);
      repeat (12) tick();
      for (int seg = 0; seg < 60; seg++) begin
         if ($urandom_range(0, 19) == 0) begin
            sync_reset = 1'b1;
            tick();
            sync_reset = 1'b0;
         end
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
